rtc_ad_bus_ctrl: RTL and testbench

RTC_AD_BUS_CTRL -- requirements
Module: rtc_ad_bus_ctrl

---
 rtl/rtc_ad_bus_ctrl.sv | 165 ++++++++++++++++
 tb/tb_rtc_ad_bus_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/rtc_ad_bus_ctrl.sv
// RTC multiplexed address/data bus controller with N_REQ requester channels.
// Define RTC_RR_ARB_EN for round-robin arbitration (default: fixed priority).
module rtc_ad_bus_ctrl #(
  parameter int DATA_W = 8,
  parameter int N_REQ  = 3,
  parameter int T_PH   = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        req_we,
  input  logic [N_REQ*DATA_W-1:0] req_addr,
  input  logic [N_REQ*DATA_W-1:0] req_wdata,
  output logic [N_REQ-1:0]        ack,
  output logic [DATA_W-1:0]       rdata,
  output logic                    busy,
  output logic [DATA_W-1:0]       bus_dout,
  input  logic [DATA_W-1:0]       bus_din,
  output logic                    bus_oe,
  output logic                    cs_n,
  output logic                    ad_n,
  output logic                    rd_n,
  output logic                    wr_n
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [7:0] RELOAD = 8'(T_PH - 1);

  typedef enum logic [2:0] {
    IDLE, ADDR, GAP, DATA, RECOV, DONE
  } state_t;

  state_t            state;
  logic [7:0]        cnt;
  logic              we_q;
  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [IW-1:0]     gnt_q;
  logic              gnt_any;
  logic [IW-1:0]     gnt_idx;

`ifdef RTC_RR_ARB_EN
  logic [IW-1:0] ptr;
  logic [IW-1:0] idx;

  // First requester at or after ptr, wrapping around.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IW'((int'(ptr) + k) % N_REQ);
      if (!gnt_any && req[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = idx;
      end
    end
  end
`else
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[k]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(k);
      end
    end
  end
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      gnt_q    <= '0;
      cs_n     <= 1'b1;
      ad_n     <= 1'b1;
      rd_n     <= 1'b1;
      wr_n     <= 1'b1;
      bus_oe   <= 1'b0;
      bus_dout <= '0;
      ack      <= '0;
      rdata    <= '0;
`ifdef RTC_RR_ARB_EN
      ptr      <= '0;
`endif
    end else begin
      ack <= '0;
      unique case (state)
        IDLE: begin
          if (gnt_any) begin
            gnt_q    <= gnt_idx;
            we_q     <= req_we[gnt_idx];
            addr_q   <= req_addr[gnt_idx*DATA_W +: DATA_W];
            wdata_q  <= req_wdata[gnt_idx*DATA_W +: DATA_W];
            state    <= ADDR;
            cnt      <= RELOAD;
            cs_n     <= 1'b0;
            ad_n     <= 1'b0;
            wr_n     <= 1'b0;
            rd_n     <= 1'b1;
            bus_oe   <= 1'b1;
            bus_dout <= req_addr[gnt_idx*DATA_W +: DATA_W];
`ifdef RTC_RR_ARB_EN
            ptr      <= IW'((int'(gnt_idx) + 1) % N_REQ);
`endif
          end
        end
        ADDR: begin
          if (cnt == 8'd0) begin
            state <= GAP;
            cs_n  <= 1'b1;
            ad_n  <= 1'b1;
            wr_n  <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        GAP: begin
          state <= DATA;
          cnt   <= RELOAD;
          cs_n  <= 1'b0;
          if (we_q) begin
            wr_n     <= 1'b0;
            bus_dout <= wdata_q;
          end else begin
            rd_n     <= 1'b0;
            bus_oe   <= 1'b0;
            bus_dout <= addr_q;
          end
        end
        DATA: begin
          if (cnt == 8'd0) begin
            state  <= RECOV;
            cnt    <= RELOAD;
            cs_n   <= 1'b1;
            rd_n   <= 1'b1;
            wr_n   <= 1'b1;
            bus_oe <= 1'b0;
            if (!we_q) rdata <= bus_din;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        RECOV: begin
          if (cnt == 8'd0) begin
            state      <= DONE;
            ack[gnt_q] <= 1'b1;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rtc_ad_bus_ctrl.sv
// Directed bench for rtc_ad_bus_ctrl: T_PH=4 main instance plus a T_PH=1 instance.
// Define RTC_RR_ARB_EN to check the round-robin build.
module tb_rtc_ad_bus_ctrl;

  localparam int TP = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  req, req_we, ack;
  logic [23:0] req_addr, req_wdata;
  logic [7:0]  rdata, bus_dout, bus_din;
  logic        busy, bus_oe, cs_n, ad_n, rd_n, wr_n;

  logic [2:0]  req1, req_we1, ack1;
  logic [23:0] req_addr1, req_wdata1;
  logic [7:0]  rdata1, bus_dout1, bus_din1;
  logic        busy1, bus_oe1, cs_n1, ad_n1, rd_n1, wr_n1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rtc_ad_bus_ctrl #(.DATA_W(8), .N_REQ(3), .T_PH(TP)) u_dut (
    .clk(clk), .reset(reset), .req(req), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .ack(ack),
    .rdata(rdata), .busy(busy), .bus_dout(bus_dout),
    .bus_din(bus_din), .bus_oe(bus_oe), .cs_n(cs_n),
    .ad_n(ad_n), .rd_n(rd_n), .wr_n(wr_n)
  );

  rtc_ad_bus_ctrl #(.DATA_W(8), .N_REQ(3), .T_PH(1)) u_dut1 (
    .clk(clk), .reset(reset), .req(req1), .req_we(req_we1),
    .req_addr(req_addr1), .req_wdata(req_wdata1), .ack(ack1),
    .rdata(rdata1), .busy(busy1), .bus_dout(bus_dout1),
    .bus_din(bus_din1), .bus_oe(bus_oe1), .cs_n(cs_n1),
    .ad_n(ad_n1), .rd_n(rd_n1), .wr_n(wr_n1)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // {cs,ad,rd,wr,oe,busy,ack,dout}; dout only compared while driven
  function automatic logic [16:0] obs();
    return {cs_n, ad_n, rd_n, wr_n, bus_oe, busy, ack,
            bus_oe ? bus_dout : 8'h00};
  endfunction

  function automatic logic [16:0] obs1();
    return {cs_n1, ad_n1, rd_n1, wr_n1, bus_oe1, busy1, ack1,
            bus_oe1 ? bus_dout1 : 8'h00};
  endfunction

  task automatic run_txn(input int ch, input bit we,
                         input logic [7:0] a, input logic [7:0] d,
                         input logic [7:0] din, input logic [7:0] exp_rd,
                         input bit drop_early);
    logic [16:0] e;
    logic [2:0]  oh;
    oh = 3'b001 << ch;
    req_we[ch] = we;
    req_addr[ch*8 +: 8] = a;
    req_wdata[ch*8 +: 8] = d;
    bus_din = ~din;
    req[ch] = 1'b1;
    for (int k = 1; k <= 3*TP + 2; k++) begin
      @(posedge clk); #1;
      if (drop_early && k == 2) req[ch] = 1'b0;
      if (k <= TP)
        e = {5'b00101, 1'b1, 3'b000, a};
      else if (k == TP + 1)
        e = {5'b11111, 1'b1, 3'b000, a};
      else if (k <= 2*TP + 1)
        e = we ? {5'b01101, 1'b1, 3'b000, d}
               : {5'b01010, 1'b1, 3'b000, 8'h00};
      else if (k <= 3*TP + 1)
        e = {5'b11110, 1'b1, 3'b000, 8'h00};
      else
        e = {5'b11110, 1'b1, oh, 8'h00};
      check($sformatf("txn_ch%0d_c%0d", ch, k), obs(), e);
      bus_din = (k == 2*TP + 1) ? din : ~din;
    end
    check($sformatf("rdata_ch%0d", ch), rdata, exp_rd);
    req[ch] = 1'b0;
    @(posedge clk); #1;
    check($sformatf("idle_ch%0d", ch), {busy, ack}, 4'h0);
  endtask

  task automatic wait_ack(output bit got);
    got = 1'b0;
    for (int n = 0; n < 60 && !got; n++) begin
      @(posedge clk); #1;
      if (ack != 3'b000) got = 1'b1;
    end
  endtask

  initial begin
    logic [16:0] t1 [5];
    int          ord [4];
    int          n_ord;
    bit          got;
    logic [2:0]  acc;

    reset = 1'b1;
    req = '0; req_we = '0; req_addr = '0; req_wdata = '0; bus_din = '0;
    req1 = '0; req_we1 = '0; req_addr1 = '0; req_wdata1 = '0; bus_din1 = '0;
    @(posedge clk); #1;
    check("reset_state", {cs_n, ad_n, rd_n, wr_n, bus_oe, busy, ack,
                          bus_dout, rdata}, {4'hF, 1'b0, 1'b0, 3'b000,
                          8'h00, 8'h00});
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // ch1 write, req dropped mid-transaction must still complete
    run_txn(1, 1'b1, 8'h21, 8'h5A, 8'h00, 8'h00, 1'b1);
    run_txn(0, 1'b0, 8'h10, 8'h00, 8'h37, 8'h37, 1'b0);
    run_txn(2, 1'b1, 8'h33, 8'hC4, 8'h00, 8'h37, 1'b0);

    // arbitration with all three requesting
`ifdef RTC_RR_ARB_EN
    ord = '{0, 1, 2, 0}; n_ord = 4;
`else
    ord = '{0, 1, 2, 0}; n_ord = 3;
`endif
    req_we = 3'b111;
    req_addr = 24'h03_02_01;
    req_wdata = 24'hC3_C2_C1;
    req = 3'b111;
    for (int i = 0; i < n_ord; i++) begin
      wait_ack(got);
      check($sformatf("arb_wait%0d", i), {31'b0, got}, 32'd1);
      check($sformatf("arb_order%0d", i), ack, 3'b001 << ord[i]);
`ifdef RTC_RR_ARB_EN
      if (i != 0) req[ord[i]] = 1'b0;
`else
      req[ord[i]] = 1'b0;
`endif
      @(posedge clk); #1;
      check($sformatf("arb_pulse%0d", i), ack, 3'b000);
    end
    req = '0;
    repeat (2) @(posedge clk);
    #1;

    // reset during write DATA cycle 2
    req_we[2] = 1'b1;
    req_addr[23:16] = 8'h44;
    req_wdata[23:16] = 8'hE7;
    req[2] = 1'b1;
    repeat (TP + 3) @(posedge clk);
    #1;
    check("mid_in_data", {wr_n, bus_oe, bus_dout}, {1'b0, 1'b1, 8'hE7});
    reset = 1'b1;
    req[2] = 1'b0;
    @(posedge clk); #1;
    check("mid_reset", {cs_n, ad_n, rd_n, wr_n, bus_oe, busy, ack,
                        bus_dout, rdata}, {4'hF, 1'b0, 1'b0, 3'b000,
                        8'h00, 8'h00});
    reset = 1'b0;
    acc = '0;
    repeat (20) begin
      @(posedge clk); #1;
      acc |= ack;
    end
    check("no_ack_after_reset", acc, 3'b000);
    run_txn(2, 1'b1, 8'h5C, 8'hA3, 8'h00, 8'h00, 1'b0);

    // T_PH=1: latency 5, address latched at grant
    t1 = '{ {5'b00101, 1'b1, 3'b000, 8'h44},
            {5'b11111, 1'b1, 3'b000, 8'h44},
            {5'b01101, 1'b1, 3'b000, 8'h99},
            {5'b11110, 1'b1, 3'b000, 8'h00},
            {5'b11110, 1'b1, 3'b001, 8'h00} };
    req_we1[0] = 1'b1;
    req_addr1[7:0] = 8'h44;
    req_wdata1[7:0] = 8'h99;
    req1[0] = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      check($sformatf("tph1_c%0d", k + 1), obs1(), t1[k]);
      if (k == 0) req_addr1[7:0] = 8'h77;
      if (k == 4) req1[0] = 1'b0;
    end
    @(posedge clk); #1;
    check("tph1_idle", {busy1, ack1}, 4'h0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
